// File: rtl/step_judge_pkg.sv
// step_judge_pkg: arrow codes, play states and helper functions shared
// by the step judge, its interface and any display logic.
package step_judge_pkg;

    localparam logic [4:0] ARROW_UP    = 5'd10;
    localparam logic [4:0] ARROW_DOWN  = 5'd11;
    localparam logic [4:0] ARROW_LEFT  = 5'd12;
    localparam logic [4:0] ARROW_RIGHT = 5'd13;
    localparam logic [4:0] ARROW_UD    = 5'd14;
    localparam logic [4:0] ARROW_UL    = 5'd15;
    localparam logic [4:0] ARROW_UR    = 5'd16;
    localparam logic [4:0] ARROW_DL    = 5'd17;
    localparam logic [4:0] ARROW_DR    = 5'd18;
    localparam logic [4:0] ARROW_LR    = 5'd19;
    localparam logic [4:0] ARROW_NONE  = 5'd20;

    typedef enum logic [1:0] {
        BeginState = 2'd0,
        PauseState = 2'd1
    } state_t;

    // Button mask order is {up, down, left, right}.
    function automatic logic [3:0] arrow_mask(input logic [4:0] code);
        case (code)
            ARROW_UP:    return 4'b1000;
            ARROW_DOWN:  return 4'b0100;
            ARROW_LEFT:  return 4'b0010;
            ARROW_RIGHT: return 4'b0001;
            ARROW_UD:    return 4'b1100;
            ARROW_UL:    return 4'b1010;
            ARROW_UR:    return 4'b1001;
            ARROW_DL:    return 4'b0110;
            ARROW_DR:    return 4'b0101;
            ARROW_LR:    return 4'b0011;
            default:     return 4'b0000;
        endcase
    endfunction

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Maps an LFSR value onto one of the eleven arrow codes 10..20.
    function automatic logic [4:0] arrow_from_lfsr(input logic [7:0] v);
        return ARROW_UP + 5'(v % 8'd11);
    endfunction

endpackage

// File: rtl/step_judge_if.sv
// step_judge_if: player/beat inputs and judge outputs of the step judge.
// master drives beat and buttons; slave (the judge) drives the results.
interface step_judge_if;
    import step_judge_pkg::*;

    logic       metronome_clk;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_pause;
    state_t     state;
    logic [4:0] cur_arrow0;
    logic [4:0] cur_arrow1;
    logic [4:0] cur_arrow2;
    logic [4:0] cur_arrow3;
    logic [13:0] score;
    logic [13:0] comboCount;
    logic       hit;
    logic       miss;

    modport master (
        output metronome_clk, btn_up, btn_down, btn_left, btn_right,
        output btn_pause,
        input  state, cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3,
        input  score, comboCount, hit, miss
    );

    modport slave (
        input  metronome_clk, btn_up, btn_down, btn_left, btn_right,
        input  btn_pause,
        output state, cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3,
        output score, comboCount, hit, miss
    );

endinterface

// File: rtl/step_judge_sync_edge.sv
// sync_edge: 2-flop synchronizer plus rising-edge pulse for one async input.
// Ports: clk, rst (sync, active-high), i_async in, o_rise one-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_last <= r_sync;
        end
    end

    // Pulse is combinational so the consumer acts on the third clk edge.
    assign o_rise = r_sync & ~r_last;

endmodule

// File: rtl/step_judge.sv
// step_judge: rhythm-game judge; scores button presses on each beat
// against a 4-deep arrow queue refilled from an LFSR.
// Ports: clk, rst (sync, active-high); bus (slave): metronome_clk, btn_*
// in; state, cur_arrow0..3, score, comboCount, hit, miss out (registered).
module step_judge
    import step_judge_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         MAX_COUNT   = 9999,
    parameter int         BONUS_COMBO = 10
) (
    input  logic        clk,
    input  logic        rst,
    step_judge_if.slave bus
);

    localparam logic [13:0] C_MAX   = 14'(MAX_COUNT);
    localparam logic [13:0] C_BONUS = 14'(BONUS_COMBO);

    logic [5:0]  w_raw;
    logic [5:0]  w_rise;
    logic [3:0]  w_btn;
    logic        w_pause;
    logic        w_beat;

    state_t      r_state;
    logic [4:0]  r_arrow [4];
    logic [13:0] r_score;
    logic [13:0] r_combo;
    logic [3:0]  r_press;
    logic [7:0]  r_lfsr;
    logic        r_hit;
    logic        r_miss;

    logic [3:0]  w_req;
    logic        w_hit;
    logic        w_miss;
    logic [1:0]  w_inc;
    logic [14:0] w_score_sum;
    logic [13:0] w_score_nxt;
    logic [13:0] w_combo_nxt;

    assign w_raw = {bus.metronome_clk, bus.btn_pause,
                    bus.btn_up, bus.btn_down,
                    bus.btn_left, bus.btn_right};

    for (genvar g = 0; g < 6; g++) begin : g_sync
        sync_edge u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (w_raw[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_btn   = w_rise[3:0];
    assign w_pause = w_rise[4];
    assign w_beat  = w_rise[5];

    assign w_req  = arrow_mask(r_arrow[0]);
    assign w_hit  = (r_press == w_req) && (w_req != 4'd0);
    // Empty arrow with no press is neither a hit nor a miss.
    assign w_miss = !w_hit && !((w_req == 4'd0) && (r_press == 4'd0));

    // Bonus decided on the combo value before this hit is counted.
    assign w_inc       = (r_combo < C_BONUS) ? 2'd1 : 2'd2;
    assign w_score_sum = {1'b0, r_score} + {13'd0, w_inc};
    assign w_score_nxt = (w_score_sum > {1'b0, C_MAX}) ?
                         C_MAX : w_score_sum[13:0];
    assign w_combo_nxt = (r_combo >= C_MAX) ? C_MAX : r_combo + 14'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PauseState;
            r_arrow[0] <= ARROW_NONE;
            r_arrow[1] <= ARROW_NONE;
            r_arrow[2] <= ARROW_NONE;
            r_arrow[3] <= ARROW_NONE;
            r_score    <= '0;
            r_combo    <= '0;
            r_press    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            // Pause wins over a coincident beat.
            if (w_pause) begin
                if (r_state == BeginState) begin
                    r_state <= PauseState;
                    r_press <= '0;
                end else begin
                    r_state <= BeginState;
                end
            end else if (r_state == BeginState) begin
                if (w_beat) begin
                    unique case (1'b1)
                        w_hit: begin
                            r_hit   <= 1'b1;
                            r_combo <= w_combo_nxt;
                            r_score <= w_score_nxt;
                        end
                        w_miss: begin
                            r_miss  <= 1'b1;
                            r_combo <= '0;
                        end
                        default: ;
                    endcase
                    r_arrow[0] <= r_arrow[1];
                    r_arrow[1] <= r_arrow[2];
                    r_arrow[2] <= r_arrow[3];
                    r_arrow[3] <= arrow_from_lfsr(r_lfsr);
                    r_lfsr     <= lfsr_next(r_lfsr);
                    // A press landing on the beat belongs to the next one.
                    r_press    <= w_btn;
                end else begin
                    r_press <= r_press | w_btn;
                end
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.cur_arrow0 = r_arrow[0];
    assign bus.cur_arrow1 = r_arrow[1];
    assign bus.cur_arrow2 = r_arrow[2];
    assign bus.cur_arrow3 = r_arrow[3];
    assign bus.score      = r_score;
    assign bus.comboCount = r_combo;
    assign bus.hit        = r_hit;
    assign bus.miss       = r_miss;

endmodule

// File: tb/tb_step_judge.sv
// tb_step_judge: table-driven, hand-sequenced and random checks of
// step_judge against a behavioural game model.
module tb_step_judge;

    localparam int MAXC = 9999;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    step_judge_if bus ();

    step_judge #(
        .LFSR_SEED   (8'hA5),
        .MAX_COUNT   (MAXC),
        .BONUS_COMBO (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model of the game: 0 = playing, 1 = paused.
    int         m_state;
    int         m_q [4];
    int         m_lfsr;
    int         m_score;
    int         m_combo;
    logic [3:0] m_press;

    logic [3:0] masks [11] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                               4'b1100, 4'b1010, 4'b1001, 4'b0110,
                               4'b0101, 4'b0011, 4'b0000};

    typedef struct {
        int sel;
        bit eh;
        bit em;
        int score;
        int combo;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [3:0] mask_of(input int code);
        if (code < 10 || code > 20) return 4'b0000;
        return masks[code - 10];
    endfunction

    function automatic int lfsr_step(input int v);
        int taps [4] = '{8, 6, 5, 4};
        int fb = 0;
        for (int i = 0; i < 4; i++) fb = fb ^ ((v >> (taps[i] - 1)) & 1);
        return ((v << 1) | fb) & 255;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_state = 1;
        for (int i = 0; i < 4; i++) m_q[i] = 20;
        m_lfsr  = 8'hA5;
        m_score = 0;
        m_combo = 0;
        m_press = 4'b0;
    endfunction

    function automatic void model_pause();
        if (m_state == 0) begin
            m_state = 1;
            m_press = 4'b0;
        end else begin
            m_state = 0;
        end
    endfunction

    function automatic void model_beat(input bit pause, input logic [3:0] coinc,
                                       output bit eh, output bit em);
        logic [3:0] need;
        eh = 1'b0;
        em = 1'b0;
        if (pause) begin
            model_pause();
        end else if (m_state == 0) begin
            need = mask_of(m_q[0]);
            if (need != 4'b0 && m_press == need) begin
                eh = 1'b1;
                m_score = imin(MAXC, m_score + ((m_combo < 10) ? 1 : 2));
                m_combo = imin(MAXC, m_combo + 1);
            end else if (!(need == 4'b0 && m_press == 4'b0)) begin
                em = 1'b1;
                m_combo = 0;
            end
            m_q[0] = m_q[1];
            m_q[1] = m_q[2];
            m_q[2] = m_q[3];
            m_q[3] = 10 + (m_lfsr % 11);
            m_lfsr = lfsr_step(m_lfsr);
            m_press = coinc;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_btn(input logic [3:0] m);
        bus.btn_up    = m[3];
        bus.btn_down  = m[2];
        bus.btn_left  = m[1];
        bus.btn_right = m[0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, " state"}, 32'(bus.state), 32'(m_state));
        chk({tag, " arrows"},
            {12'd0, bus.cur_arrow0, bus.cur_arrow1,
             bus.cur_arrow2, bus.cur_arrow3},
            {12'd0, 5'(m_q[0]), 5'(m_q[1]), 5'(m_q[2]), 5'(m_q[3])});
        chk({tag, " score"}, 32'(bus.score), 32'(m_score));
        chk({tag, " combo"}, 32'(bus.comboCount), 32'(m_combo));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        model_reset();
    endtask

    task automatic do_press(input logic [3:0] m);
        drive_btn(m);
        tick(4);
        drive_btn(4'b0);
        tick(4);
        if (m_state == 0) m_press = m_press | m;
    endtask

    task automatic do_pause(input string tag);
        bus.btn_pause = 1'b1;
        tick(4);
        bus.btn_pause = 1'b0;
        tick(4);
        model_pause();
        chk({tag, " state"}, 32'(bus.state), 32'(m_state));
    endtask

    // Raw edge at a negedge; the pulse must land on the third negedge.
    task automatic do_beat(input string tag, input logic [3:0] coinc,
                           input bit pause, output bit gh, output bit gm);
        logic [5:0] h;
        logic [5:0] ms;
        bit eh;
        bit em;
        bus.metronome_clk = 1'b1;
        bus.btn_pause     = pause;
        drive_btn(coinc);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            h[i]  = bus.hit;
            ms[i] = bus.miss;
        end
        bus.metronome_clk = 1'b0;
        bus.btn_pause     = 1'b0;
        drive_btn(4'b0);
        tick(3);
        model_beat(pause, coinc, eh, em);
        chk({tag, " pulses"}, {20'd0, h, ms},
            {20'd0, eh ? 6'b000100 : 6'b0, em ? 6'b000100 : 6'b0});
        check_all(tag);
        gh = h[2];
        gm = ms[2];
    endtask

    task automatic ensure_live();
        bit gh;
        bit gm;
        for (int i = 0; i < 8 && m_q[0] == 20; i++)
            do_beat("skip", 4'b0, 1'b0, gh, gm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit gh;
        bit gm;
        logic [3:0] pm;

        tbl = '{
            '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0},
            '{1, 1, 0, 1, 1}, '{1, 1, 0, 2, 2},
            '{1, 1, 0, 3, 3}, '{1, 1, 0, 4, 4},
            '{1, 1, 0, 5, 5}, '{1, 1, 0, 6, 6},
            '{1, 1, 0, 7, 7}, '{1, 1, 0, 8, 8},
            '{1, 1, 0, 9, 9}, '{1, 1, 0, 10, 10},
            '{1, 1, 0, 12, 11}, '{1, 1, 0, 14, 12},
            '{2, 0, 1, 14, 0}, '{1, 1, 0, 15, 1},
            '{0, 0, 1, 15, 0}
        };

        bus.metronome_clk = 1'b0;
        bus.btn_pause     = 1'b0;
        drive_btn(4'b0);
        rst = 1'b1;
        tick(1);

        do_reset();
        check_all("reset");
        chk("reset hit", 32'(bus.hit), 0);
        chk("reset miss", 32'(bus.miss), 0);

        for (int i = 0; i < 10; i++) do_beat("paused", 4'b0, 1'b0, gh, gm);

        do_pause("start");

        for (int i = 0; i < 19; i++) begin
            case (tbl[i].sel)
                1:       pm = mask_of(m_q[0]);
                2:       pm = ~mask_of(m_q[0]);
                default: pm = 4'b0;
            endcase
            if (pm != 4'b0) do_press(pm);
            do_beat("table", 4'b0, 1'b0, gh, gm);
            chk("table hit", 32'(gh), 32'(tbl[i].eh));
            chk("table miss", 32'(gm), 32'(tbl[i].em));
            chk("table score", 32'(bus.score), 32'(tbl[i].score));
            chk("table combo", 32'(bus.comboCount), 32'(tbl[i].combo));
        end

        // Press coincident with a beat carries over to the next beat.
        do_beat("coinc a", mask_of(m_q[1]), 1'b0, gh, gm);
        chk("coinc a miss", 32'(gm), 1);
        do_beat("coinc b", 4'b0, 1'b0, gh, gm);
        chk("coinc b hit", 32'(gh), 1);

        // Pause edge on a beat: no judgement, no shift.
        do_press(mask_of(m_q[0]));
        do_beat("pause+beat", 4'b0, 1'b1, gh, gm);
        chk("pause+beat st", 32'(bus.state), 1);
        do_press(4'b1111);
        do_pause("resume");
        ensure_live();
        do_beat("after pause", 4'b0, 1'b0, gh, gm);

        // Saturation from a forced near-limit total.
        ensure_live();
        force dut.r_score = 14'd9998;
        force dut.r_combo = 14'd9998;
        tick(1);
        release dut.r_score;
        release dut.r_combo;
        tick(1);
        m_score = 9998;
        m_combo = 9998;
        check_all("preload");
        for (int i = 0; i < 2; i++) begin
            ensure_live();
            do_press(mask_of(m_q[0]));
            do_beat("sat", 4'b0, 1'b0, gh, gm);
            chk("sat hit", 32'(gh), 1);
        end
        chk("sat score", 32'(bus.score), 9999);
        chk("sat combo", 32'(bus.comboCount), 9999);

        for (int k = 0; k < 40; k++) begin
            int r;
            logic [3:0] co;
            bit pz;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_pause("rand pause");
            end else begin
                if (r < 6) pm = mask_of(m_q[0]);
                else pm = 4'($urandom_range(0, 15));
                if (pm != 4'b0) do_press(pm);
                co = ($urandom_range(0, 3) == 0) ?
                     4'($urandom_range(1, 15)) : 4'b0;
                pz = ($urandom_range(0, 9) == 0);
                do_beat("rand", co, pz, gh, gm);
            end
        end

        // Reset mid-beat drops the pending press.
        if (m_state == 1) do_pause("pre-reset");
        do_press(4'b1111);
        do_reset();
        check_all("mid reset");
        do_pause("post reset");
        do_beat("post reset", 4'b0, 1'b0, gh, gm);
        chk("post reset miss", 32'(gm), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
